// File: rtl/pc_fetch_ctrl.sv
// IF-stage controller: owns the PC, arbitrates redirects (exception, branch, jump),
// handles stall/halt and runs the request/ready handshake with instruction memory.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc,
  input  logic        halt_req,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        if_valid,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t      state;
  logic        in_fetch;
  logic        halt_go;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  // Handshake: imem_req is held high for the whole FETCH state; a word is
  // accepted (if_valid) only in a cycle where imem_ready=1 and nothing
  // redirects, stalls or halts the front end.
  always_comb begin
    in_fetch    = (state == FETCH);
    pc_plus4    = pc + 32'd4;
    halt_go     = in_fetch & halt_req & ~exc & ~br_taken;
    imem_req    = in_fetch;
    if_valid    = in_fetch & imem_ready & ~stall & ~exc & ~br_taken & ~jump & ~halt_req;
    flush_if_id = in_fetch & (exc | br_taken | jump | halt_req);
    flush_id_ex = in_fetch & (exc | br_taken);

    pc_next = pc;
    if (in_fetch) begin
      if (exc)             pc_next = EXC_PC;
      else if (br_taken)   pc_next = {br_target[31:2], 2'b00};
      else if (jump)       pc_next = {jump_target[31:2], 2'b00};
      else if (halt_req)   pc_next = pc;
      else if (stall)      pc_next = pc;
      else if (imem_ready) pc_next = pc_plus4;
      else                 pc_next = pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          pc <= pc_next;
          if (halt_go) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          state  <= HALT;
          halted <= 1'b1;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: sequential fetch, memory wait, redirects,
// PC wrap, halt and asynchronous reset out of HALT.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exc;
  logic        halt_req;
  logic        imem_ready;
  logic [31:0] pc;
  logic        imem_req;
  logic        if_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        halted;

  int err_cnt;
  int chk_cnt;

  pc_fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jump       (jump),
    .jump_target(jump_target),
    .exc        (exc),
    .halt_req   (halt_req),
    .imem_ready (imem_ready),
    .pc         (pc),
    .imem_req   (imem_req),
    .if_valid   (if_valid),
    .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex),
    .halted     (halted)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns 1 ns after the edge so registered values are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall       = 1'b0;
    br_taken    = 1'b0;
    br_target   = 32'h0;
    jump        = 1'b0;
    jump_target = 32'h0;
    exc         = 1'b0;
    halt_req    = 1'b0;
  endtask

  initial begin
    err_cnt    = 0;
    chk_cnt    = 0;
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    clear_inputs();

    // Reset values
    #12;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);

    // BOOT: one cycle with everything quiet
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    #1;
    check("boot_pc", pc, 32'h0000_3000);
    check("boot_imem_req", {31'b0, imem_req}, 32'd0);
    check("boot_if_valid", {31'b0, if_valid}, 32'd0);

    // Sequential fetch
    step();
    check("fetch0_pc", pc, 32'h0000_3000);
    check("fetch0_imem_req", {31'b0, imem_req}, 32'd1);
    check("fetch0_if_valid", {31'b0, if_valid}, 32'd1);
    step();
    check("fetch1_pc", pc, 32'h0000_3004);
    step();
    check("fetch2_pc", pc, 32'h0000_3008);

    // Memory not ready for 3 cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wait_if_valid", {31'b0, if_valid}, 32'd0);
      check("wait_imem_req", {31'b0, imem_req}, 32'd1);
      step();
      check("wait_pc", pc, 32'h0000_3008);
    end
    imem_ready = 1'b1;
    #1;
    check("ready_if_valid", {31'b0, if_valid}, 32'd1);
    step();
    check("ready_pc", pc, 32'h0000_300C);
    step();
    check("seq_pc", pc, 32'h0000_3010);

    // Branch beats stall; low target bits dropped
    stall     = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_3402;
    #1;
    check("br_flush_if_id", {31'b0, flush_if_id}, 32'd1);
    check("br_flush_id_ex", {31'b0, flush_id_ex}, 32'd1);
    check("br_if_valid", {31'b0, if_valid}, 32'd0);
    step();
    check("br_pc", pc, 32'h0000_3400);
    clear_inputs();

    // Exception beats jump
    exc         = 1'b1;
    jump        = 1'b1;
    jump_target = 32'h0000_3100;
    #1;
    check("exc_flush_if_id", {31'b0, flush_if_id}, 32'd1);
    check("exc_flush_id_ex", {31'b0, flush_id_ex}, 32'd1);
    step();
    check("exc_pc", pc, 32'h0000_4180);

    // Jump alone
    exc = 1'b0;
    #1;
    check("jmp_flush_if_id", {31'b0, flush_if_id}, 32'd1);
    check("jmp_flush_id_ex", {31'b0, flush_id_ex}, 32'd0);
    check("jmp_if_valid", {31'b0, if_valid}, 32'd0);
    step();
    check("jmp_pc", pc, 32'h0000_3100);
    clear_inputs();

    // Stall alone holds pc, no flush
    stall = 1'b1;
    #1;
    check("stall_flush_if_id", {31'b0, flush_if_id}, 32'd0);
    check("stall_if_valid", {31'b0, if_valid}, 32'd0);
    step();
    check("stall_pc", pc, 32'h0000_3100);
    clear_inputs();

    // Redirect while memory not ready, then wrap at top of address space
    imem_ready = 1'b0;
    br_taken   = 1'b1;
    br_target  = 32'hFFFF_FFFC;
    step();
    check("wrap_br_pc", pc, 32'hFFFF_FFFC);
    check("wrap_imem_req", {31'b0, imem_req}, 32'd1);
    clear_inputs();
    imem_ready = 1'b1;
    step();
    check("wrap_pc", pc, 32'h0000_0000);

    // Move to 3020 and halt there
    jump        = 1'b1;
    jump_target = 32'h0000_3020;
    step();
    check("pre_halt_pc", pc, 32'h0000_3020);
    clear_inputs();
    halt_req = 1'b1;
    #1;
    check("halt_flush_if_id", {31'b0, flush_if_id}, 32'd1);
    check("halt_flush_id_ex", {31'b0, flush_id_ex}, 32'd0);
    check("halt_if_valid", {31'b0, if_valid}, 32'd0);
    check("halt_pre_halted", {31'b0, halted}, 32'd0);
    step();
    check("halt_pc", pc, 32'h0000_3020);
    check("halt_halted", {31'b0, halted}, 32'd1);
    check("halt_imem_req", {31'b0, imem_req}, 32'd0);
    clear_inputs();

    // Exception ignored in HALT
    exc = 1'b1;
    #1;
    check("halt_exc_flush", {30'b0, flush_if_id, flush_id_ex}, 32'd0);
    step();
    check("halt_exc_pc", pc, 32'h0000_3020);
    check("halt_exc_halted", {31'b0, halted}, 32'd1);
    clear_inputs();

    // Asynchronous reset mid-cycle out of HALT
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_pc", pc, 32'h0000_3000);
    check("areset_halted", {31'b0, halted}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("reboot_pc", pc, 32'h0000_3000);
    check("reboot_imem_req", {31'b0, imem_req}, 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Controls the IF stage of the 5-stage pipelined CPU. Owns the PC register and computes PC+4 for sequential fetch. Arbitrates redirects from exception, EX-stage branch, ID-stage jump and the hazard-unit stall. Runs a request/ready handshake with instruction memory and drives the IF/ID and ID/EX flush strobes.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
EXC_PC, 32'h0000_4180, exception handler entry address.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  load-use stall from hazard unit; hold PC
br_taken  in  1  EX-stage branch resolved taken
br_target  in  32  branch target address
jump  in  1  ID-stage j/jal/jr
jump_target  in  32  jump target address
exc  in  1  exception request
halt_req  in  1  syscall-halt decoded in ID
imem_ready  in  1  instruction memory returns word this cycle
pc  out  32  current fetch address (registered)
imem_req  out  1  fetch request
if_valid  out  1  fetched word is written into IF/ID this cycle
flush_if_id  out  1  clear IF/ID register
flush_id_ex  out  1  clear ID/EX register
halted  out  1  core halted

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, state=BOOT. All outputs 0 while in reset and in BOOT.
- States are BOOT, FETCH and HALT.
  - BOOT -> FETCH unconditionally after 1 cycle.
  - FETCH -> HALT when halt_req=1 and exc=0 and br_taken=0.
  - HALT is terminal. Only rst_n exits it.
- FETCH outputs (combinational from state):
  - imem_req=1.
  - if_valid = imem_ready & ~stall & ~exc & ~br_taken & ~jump & ~halt_req.
- HALT outputs: imem_req=0, if_valid=0, flushes=0, halted=1 (registered). pc frozen. All inputs ignored, including exc.
- Next-PC priority in FETCH, highest first:
  1. exc -> EXC_PC
  2. br_taken -> br_target
  3. jump -> jump_target
  4. halt_req -> hold
  5. stall -> hold
  6. imem_ready -> pc+4
  7. otherwise hold (waiting on memory).
- Flushes, combinational, FETCH only:
  - exc or br_taken: flush_if_id=1 and flush_id_ex=1.
  - jump (no higher redirect): flush_if_id=1 only.
  - halt_req: flush_if_id=1.
  - stall alone: no flush.
- A redirect while imem_ready=0 abandons the outstanding fetch. The new PC is presented on the next cycle and imem_req stays 1.
- Targets: bits [1:0] of br_target and jump_target are forced to 0 when loaded. EXC_PC and RESET_PC are used as given.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Simultaneous events resolve by the priority list above. Example: stall with br_taken -> redirect wins and stall is ignored.
- Latency: a redirect asserted in cycle N gives the new pc in cycle N+1. Sequential advance is 1 cycle per imem_ready.
- Reset asserted mid-operation (any state, any cycle phase) immediately forces the reset values. BOOT is re-entered.

Test Plan:
- Reset then imem_ready=1 constantly, no hazards:
  - pc = 3000 in BOOT, then 3000, 3004, 3008 in FETCH.
  - imem_req=1 and if_valid=1 from the first FETCH cycle.
- imem_ready low for 3 cycles at pc=3008:
  - pc holds 3008 and if_valid=0 for those 3 cycles.
  - Advances to 300C the cycle after imem_ready=1.
- stall=1 and br_taken=1 with br_target=32'h0000_3402 at pc=3010:
  - Next pc=3400.
  - flush_if_id=1 and flush_id_ex=1 in that cycle, if_valid=0.
- exc=1 with jump=1 (jump_target=3100):
  - pc goes to 4180, both flushes=1.
  - The same test with jump alone gives pc=3100 with only flush_if_id=1.
- br_target=FFFF_FFFC, then imem_ready=1: pc goes FFFF_FFFC then 0000_0000.
- halt_req=1 at pc=3020:
  - pc stays 3020, halted=1, imem_req=0 thereafter.
  - exc=1 later has no effect.
  - rst_n low mid-HALT restores pc=3000 and halted=0 asynchronously.
